serial_subtractor4: RTL



---
 rtl/arith_pkg.sv | 10 +
 rtl/fullsubtractor.sv | 19 +
 rtl/serial_subtractor4.sv | 105 ++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic lab blocks: FSM state encoding and default width.
package arith_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int ARITH_W = 4;
endpackage

// File: rtl/fullsubtractor.sv
// Single-bit full subtractor, gate level, same cell style as the full adder.
module fullsubtractor (
  input  wire A,
  input  wire B,
  input  wire Bi,
  output wire D,
  output wire Bo
);
  wire axb, na, nxb, t_ab, t_bi;

  xor g_x0 (axb, A, B);
  xor g_x1 (D, axb, Bi);
  not g_n0 (na, A);
  and g_a0 (t_ab, na, B);
  // Equal operand bits pass the incoming borrow straight through.
  not g_n1 (nxb, axb);
  and g_a1 (t_bi, nxb, Bi);
  or  g_o0 (Bo, t_ab, t_bi);
endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial ripple-borrow subtractor: D = A - B, LSB first, one bit per clock,
// with a start/done handshake and registered results.
module serial_subtractor4
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d, d_q, d_d;
  logic             br_q, br_d, bo_q, bo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bit_d, bit_bo;
  logic last_bit;

  fullsubtractor u_fs (
    .A  (ra_q[0]),
    .B  (rb_q[0]),
    .Bi (br_q),
    .D  (bit_d),
    .Bo (bit_bo)
  );

  assign last_bit = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ra_d  = ra_q;
    rb_d  = rb_q;
    rd_d  = rd_q;
    br_d  = br_q;
    cnt_d = cnt_q;
    d_d   = d_q;
    bo_d  = bo_q;
    if (state_q == S_IDLE && start) begin
      ra_d  = A;
      rb_d  = B;
      rd_d  = '0;
      br_d  = 1'b0;
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      ra_d  = {1'b0, ra_q[WIDTH-1:1]};
      rb_d  = {1'b0, rb_q[WIDTH-1:1]};
      rd_d  = {bit_d, rd_q[WIDTH-1:1]};
      br_d  = bit_bo;
      cnt_d = cnt_q + 1'b1;
      // Publish on the edge into DONE so D/Bo are already stable while done is high.
      if (last_bit) begin
        d_d  = {bit_d, rd_q[WIDTH-1:1]};
        bo_d = bit_bo;
      end
    end
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DONE);
    done = (state_q == S_DONE);
    D    = d_q;
    Bo   = bo_q;
  end
endmodule
